reg_file_ops: RTL and testbench
===============================

# reg_file_ops

Parametrised register file of DEPTH words, each W bits, with one write port and two combinational read ports. The write port performs a selectable per-word operation (load, increment, decrement, shift-left) and reports a registered carry/borrow/shift-out flag. Optional write-to-read bypass and optional hardwired-zero register 0. Sits between the datapath ALU and the operand multiplexers, replacing banks of discrete single-word registers.

## Interface

Parameters:
- W, default 4: word width in bits, W >= 2.
- DEPTH, default 4: number of words, DEPTH >= 2; need not be a power of two.
- AW, default $clog2(DEPTH): address width.
- BYPASS, default 1: 1 = read ports forward the pending write value; 0 = read ports show stored contents only.
- ZERO_REG0, default 0: 1 = word 0 always reads zero and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all words and carry_out immediately.
- clear  in  1  synchronous clear of all words and carry_out.
- write_enable  in  1  perform op on word write_addr this cycle.
- op  in  2  00 LOAD, 01 INC, 10 DEC, 11 SHL.
- write_addr  in  AW  target word.
- write_data  in  W  LOAD data; bit 0 is the SHL serial input.
- read_addr_a  in  AW  read port A address.
- read_addr_b  in  AW  read port B address.
- read_data_a  out  W  port A data, combinational.
- read_data_b  out  W  port B data, combinational.
- carry_out  out  1  registered flag from the most recent effective write.

## Operation

- Reset (reset = 0): every word = 0, carry_out = 0, asynchronously; held while asserted. Read outputs show 0 for every address.
- Priority per rising edge: clear, then write_enable. clear = 1: all words = 0, carry_out = 0, write ignored.
- Next value nv of word R = mem[write_addr]:
  - LOAD: nv = write_data; carry = 0.
  - INC: nv = (R + 1) mod 2^W; carry = 1 iff R = all ones.
  - DEC: nv = (R - 1) mod 2^W; carry = 1 iff R = 0 (borrow).
  - SHL: nv = {R[W-2:0], write_data[0]}; carry = R[W-1].
- Effective write: write_enable = 1, clear = 0, write_addr < DEPTH, and not (ZERO_REG0 = 1 and write_addr = 0). On an effective write: mem[write_addr] <= nv, carry_out <= carry. Otherwise all words and carry_out hold.
- Reads: read_data_x = mem[read_addr_x]; returns 0 when read_addr_x >= DEPTH, or when ZERO_REG0 = 1 and read_addr_x = 0.
- Bypass (BYPASS = 1): if an effective write targets read_addr_x this cycle, read_data_x = nv (combinational from current inputs). Both ports bypass independently and may bypass simultaneously. No bypass when clear = 1.
- Non-target words are never modified by a write.

## Timing

- Write latency: one clock edge; stored value visible on the non-bypassed read path in the cycle after the edge.
- Bypass path: zero-cycle; read_data_x follows write_data/op/write_addr combinationally within the same cycle.
- carry_out changes only on an effective write edge, clear edge, or reset; it is stable between edges.
- Back-to-back INC/DEC/SHL to the same word each cycle operate on the value written on the previous edge (no read hazard).
- Reset asserted mid-operation: state clears without waiting for clk; the first edge after reset returns to 1 applies normal behaviour.

## Test plan

- Reset and load (W=4, DEPTH=4): pulse reset low mid-cycle -> all reads 0, carry_out 0 immediately; LOAD 4'hA to word 2 -> after edge read_data_a(addr 2) = 4'hA, carry_out = 0.
- INC wrap: word 1 = 4'hE, INC twice -> 4'hF carry 0, then 4'h0 carry 1; DEC on 4'h0 -> 4'hF carry 1; DEC on 4'h5 -> 4'h4 carry 0.
- SHL: word 3 = 4'b1001, SHL with write_data[0] = 1 -> 4'b0011, carry_out = 1; again with write_data[0] = 0 -> 4'b0110, carry_out = 0.
- Bypass: word 0 = 4'h3, same-cycle INC on word 0 with read_addr_a = read_addr_b = 0 -> both ports show 4'h4 before the edge with BYPASS=1, 4'h3 with BYPASS=0.
- Clear priority: clear = 1 and write_enable = 1 LOAD 4'h7 to word 1 with carry_out = 1 -> after edge all words 0, carry_out 0, read port shows 0 before the edge (no bypass).
- Boundaries: DEPTH=3, write to address 3 -> no word changes, carry_out holds, read of address 3 = 0; ZERO_REG0=1, LOAD 4'hF to word 0 -> word 0 reads 0, carry_out unchanged.

Source files
------------

// File: rtl/reg_file_ops_if.sv
// Bus bundle for reg_file_ops: write-port controls, two read ports and the carry flag.
// The master drives controls and addresses; the register file returns read data and carry.
interface reg_file_ops_if #(
    parameter int W  = 4,
    parameter int AW = 2
);
    logic          clear;
    logic          write_enable;
    logic [1:0]    op;
    logic [AW-1:0] write_addr;
    logic [W-1:0]  write_data;
    logic [AW-1:0] read_addr_a;
    logic [AW-1:0] read_addr_b;
    logic [W-1:0]  read_data_a;
    logic [W-1:0]  read_data_b;
    logic          carry_out;

    modport master (
        output clear, write_enable, op, write_addr, write_data, read_addr_a, read_addr_b,
        input  read_data_a, read_data_b, carry_out
    );

    modport slave (
        input  clear, write_enable, op, write_addr, write_data, read_addr_a, read_addr_b,
        output read_data_a, read_data_b, carry_out
    );
endinterface

// File: rtl/reg_file_ops.sv
// Register file with one operate-on-write port (LOAD/INC/DEC/SHL), two combinational
// read ports, optional write-to-read bypass and optional hardwired-zero word 0.
module reg_file_ops #(
    parameter int W         = 4,
    parameter int DEPTH     = 4,
    parameter int AW        = $clog2(DEPTH),
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_ops_if.slave bus
);
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic         r_carry;

    logic [W-1:0] w_cur;
    logic [W-1:0] w_rd_a;
    logic [W-1:0] w_rd_b;
    logic [W-1:0] w_nv;
    logic         w_carry;
    logic         w_eff;
    logic         w_byp_a;
    logic         w_byp_b;

    // Returns {flag, next word}; flag is carry for INC, borrow for DEC, shift-out for SHL.
    function automatic logic [W:0] f_apply(input logic [1:0] op,
                                           input logic [W-1:0] cur,
                                           input logic [W-1:0] din);
        logic [W:0] res;
        case (op_e'(op))
            OP_LOAD: res = {1'b0, din};
            OP_INC:  res = {&cur, cur + W'(1)};
            OP_DEC:  res = {~|cur, cur - W'(1)};
            default: res = {cur[W-1], cur[W-2:0], din[0]};
        endcase
        return res;
    endfunction

    // An address maps to a real, writable/readable word.
    function automatic logic f_addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < LP_DEPTH) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    always_comb begin
        w_cur  = '0;
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.write_addr  == AW'(i)) w_cur  = r_mem[i];
            if (bus.read_addr_a == AW'(i)) w_rd_a = r_mem[i];
            if (bus.read_addr_b == AW'(i)) w_rd_b = r_mem[i];
        end
    end

    assign {w_carry, w_nv} = f_apply(bus.op, w_cur, bus.write_data);

    // No write takes effect while reset is held, so bypass cannot leak a value either.
    assign w_eff = reset & ~bus.clear & bus.write_enable & f_addr_ok(bus.write_addr);

    assign w_byp_a = (BYPASS != 0) && w_eff && (bus.write_addr == bus.read_addr_a);
    assign w_byp_b = (BYPASS != 0) && w_eff && (bus.write_addr == bus.read_addr_b);

    assign bus.read_data_a = w_byp_a ? w_nv : (f_addr_ok(bus.read_addr_a) ? w_rd_a : '0);
    assign bus.read_data_b = w_byp_b ? w_nv : (f_addr_ok(bus.read_addr_b) ? w_rd_b : '0);
    assign bus.carry_out   = r_carry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_carry <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_carry <= 1'b0;
        end else if (w_eff) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.write_addr == AW'(i)) r_mem[i] <= w_nv;
            end
            r_carry <= w_carry;
        end
    end
endmodule

// File: tb/tb_reg_file_ops.sv
// Scoreboard bench: three register-file variants (bypass, no bypass, DEPTH=3 with zero word 0)
// receive identical stimulus and are compared against a per-variant reference model.
module tb_reg_file_ops;
    localparam logic [1:0] LD = 2'd0, INC = 2'd1, DEC = 2'd2, SHL = 2'd3;
    localparam int DEP [3] = '{4, 4, 3};
    localparam int BYP [3] = '{1, 0, 1};
    localparam int Z0  [3] = '{0, 0, 1};

    typedef struct {
        string      tag;
        int         k;
        int         kind;
        logic [3:0] exp;
    } sb_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    sb_t  sb_q[$];

    logic [3:0] m  [3][4];
    logic       mc [3];

    reg_file_ops_if #(.W(4), .AW(2)) if_a ();
    reg_file_ops_if #(.W(4), .AW(2)) if_b ();
    reg_file_ops_if #(.W(4), .AW(2)) if_c ();

    reg_file_ops #(.W(4), .DEPTH(4), .BYPASS(1), .ZERO_REG0(0)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    reg_file_ops #(.W(4), .DEPTH(4), .BYPASS(0), .ZERO_REG0(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));
    reg_file_ops #(.W(4), .DEPTH(3), .BYPASS(1), .ZERO_REG0(1)) u_dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] get_obs(input int k, input int kind);
        logic [3:0] v;
        v = '0;
        case (k)
            0: v = (kind == 0) ? if_a.read_data_a : (kind == 1) ? if_a.read_data_b : {3'b0, if_a.carry_out};
            1: v = (kind == 0) ? if_b.read_data_a : (kind == 1) ? if_b.read_data_b : {3'b0, if_b.carry_out};
            default: v = (kind == 0) ? if_c.read_data_a : (kind == 1) ? if_c.read_data_b : {3'b0, if_c.carry_out};
        endcase
        return v;
    endfunction

    task automatic sb_push(input string tag, input int k, input int kind, input logic [3:0] exp);
        sb_t e;
        e.tag  = $sformatf("%s[dut%0d]", tag, k);
        e.k    = k;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_compare();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, get_obs(e.k, e.kind), e.exp);
        end
    endtask

    task automatic set_rd(input logic [1:0] ra, input logic [1:0] rb);
        if_a.read_addr_a = ra; if_a.read_addr_b = rb;
        if_b.read_addr_a = ra; if_b.read_addr_b = rb;
        if_c.read_addr_a = ra; if_c.read_addr_b = rb;
    endtask

    task automatic drive(input logic clr, input logic we, input logic [1:0] op,
                         input logic [1:0] wa, input logic [3:0] wd,
                         input logic [1:0] ra, input logic [1:0] rb);
        if_a.clear = clr; if_a.write_enable = we; if_a.op = op; if_a.write_addr = wa; if_a.write_data = wd;
        if_b.clear = clr; if_b.write_enable = we; if_b.op = op; if_b.write_addr = wa; if_b.write_data = wd;
        if_c.clear = clr; if_c.write_enable = we; if_c.op = op; if_c.write_addr = wa; if_c.write_data = wd;
        set_rd(ra, rb);
    endtask

    function automatic logic f_eff(input int k, input logic clr, input logic we, input logic [1:0] wa);
        return reset && we && !clr && (int'(wa) < DEP[k]) && !(Z0[k] == 1 && wa == 2'd0);
    endfunction

    function automatic logic [4:0] f_op(input int k, input logic [1:0] op,
                                        input logic [1:0] wa, input logic [3:0] wd);
        logic [3:0] cur;
        logic [4:0] r;
        cur = m[k][wa];
        case (op)
            LD:      r = {1'b0, wd};
            INC:     r = {cur == 4'hF, cur + 4'd1};
            DEC:     r = {cur == 4'h0, cur - 4'd1};
            default: r = {cur[3], cur[2:0], wd[0]};
        endcase
        return r;
    endfunction

    function automatic logic [3:0] f_stored(input int k, input logic [1:0] addr);
        if (int'(addr) >= DEP[k] || (Z0[k] == 1 && addr == 2'd0)) return 4'h0;
        return m[k][addr];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) m[k][i] = 4'h0;
            mc[k] = 1'b0;
        end
    endtask

    task automatic check_all_reads();
        for (int k = 0; k < 3; k++) sb_push("carry_hold", k, 2, {3'b0, mc[k]});
        for (int a = 0; a < 4; a++) begin
            set_rd(2'(a), 2'(a));
            for (int k = 0; k < 3; k++) begin
                sb_push($sformatf("rd_a_addr%0d", a), k, 0, f_stored(k, 2'(a)));
                sb_push($sformatf("rd_b_addr%0d", a), k, 1, f_stored(k, 2'(a)));
            end
            #1;
            sb_compare();
        end
    endtask

    task automatic cycle(input logic clr, input logic we, input logic [1:0] op,
                         input logic [1:0] wa, input logic [3:0] wd,
                         input logic [1:0] ra, input logic [1:0] rb);
        logic [4:0] r [3];
        logic       e [3];
        @(negedge clk);
        drive(clr, we, op, wa, wd, ra, rb);
        for (int k = 0; k < 3; k++) begin
            e[k] = f_eff(k, clr, we, wa);
            r[k] = f_op(k, op, wa, wd);
            sb_push("pre_edge_a", k, 0, (BYP[k] == 1 && e[k] && wa == ra) ? r[k][3:0] : f_stored(k, ra));
            sb_push("pre_edge_b", k, 1, (BYP[k] == 1 && e[k] && wa == rb) ? r[k][3:0] : f_stored(k, rb));
        end
        #1;
        sb_compare();
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                for (int i = 0; i < 4; i++) m[k][i] = 4'h0;
                mc[k] = 1'b0;
            end else if (e[k]) begin
                m[k][wa] = r[k][3:0];
                mc[k]    = r[k][4];
            end
            sb_push("carry_edge", k, 2, {3'b0, mc[k]});
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, op, wa, wd, ra, rb);
        sb_compare();
        check_all_reads();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        check_all_reads();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b0, 1'b0, LD, 2'd0, 4'h0, 2'd0, 2'd0);
        model_clear();
        #2;
        check_all_reads();
        #1;
        reset = 1'b1;

        cycle(1'b0, 1'b1, LD,  2'd2, 4'hA, 2'd2, 2'd2);
        cycle(1'b0, 1'b1, LD,  2'd1, 4'hE, 2'd1, 2'd1);
        cycle(1'b0, 1'b1, INC, 2'd1, 4'h0, 2'd1, 2'd1);
        cycle(1'b0, 1'b1, INC, 2'd1, 4'h0, 2'd1, 2'd1);
        cycle(1'b0, 1'b1, DEC, 2'd1, 4'h0, 2'd1, 2'd1);
        cycle(1'b0, 1'b1, LD,  2'd1, 4'h5, 2'd1, 2'd1);
        cycle(1'b0, 1'b1, DEC, 2'd1, 4'h0, 2'd1, 2'd1);

        cycle(1'b0, 1'b1, LD,  2'd3, 4'h9, 2'd3, 2'd3);
        cycle(1'b0, 1'b1, SHL, 2'd3, 4'h1, 2'd3, 2'd3);
        cycle(1'b0, 1'b1, SHL, 2'd3, 4'h0, 2'd3, 2'd3);

        cycle(1'b0, 1'b1, LD,  2'd0, 4'h3, 2'd0, 2'd0);
        cycle(1'b0, 1'b1, INC, 2'd0, 4'h0, 2'd0, 2'd0);

        // Carry set to 1, then clear collides with a LOAD to a non-zero word.
        cycle(1'b0, 1'b1, LD,  2'd2, 4'hF, 2'd2, 2'd2);
        cycle(1'b0, 1'b1, INC, 2'd2, 4'h0, 2'd2, 2'd2);
        cycle(1'b1, 1'b1, LD,  2'd1, 4'h7, 2'd1, 2'd1);

        cycle(1'b0, 1'b1, LD,  2'd2, 4'hF, 2'd2, 2'd2);
        cycle(1'b0, 1'b1, INC, 2'd2, 4'h0, 2'd2, 2'd2);
        cycle(1'b0, 1'b1, LD,  2'd3, 4'h5, 2'd3, 2'd3);
        cycle(1'b0, 1'b1, LD,  2'd0, 4'hF, 2'd0, 2'd0);

        cycle(1'b0, 1'b1, LD,  2'd1, 4'hC, 2'd1, 2'd2);
        pulse_reset();
        cycle(1'b0, 1'b1, INC, 2'd1, 4'h0, 2'd1, 2'd0);

        for (int n = 0; n < 40; n++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        check_val("sb_empty", 4'(sb_q.size()), 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
